// File: rtl/ecc_enc_pkg.sv
// Shared definitions for the ECC encoder arbiter slice.
//   - default payload / codeword / counter widths
//   - ENC_TAG: fixed low nibble appended by the test encoder
//   - output-stage FSM state encodings
//   - id_width(): smallest index width able to address n requesters
package ecc_enc_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CODE_W_DEF = 12;
  localparam int CNT_W_DEF  = 16;

  localparam logic [3:0] ENC_TAG = 4'b1010;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  function automatic int id_width(input int n);
    for (int w = 1; w < 31; w++)
      if ((1 << w) >= n) return w;
    return 31;
  endfunction
endpackage

// File: rtl/ecc_enc_arbiter_enc.sv
// Combinational test encoder shared by all requesters.
// Ports:
//   data_in  [DATA_WIDTH-1:0]  payload selected by the arbiter
//   codeword [CODE_WIDTH-1:0]  {data_in, ENC_TAG}
module test_encoder
  import ecc_enc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CODE_WIDTH = CODE_W_DEF
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [CODE_WIDTH-1:0] codeword
);
  // Codeword layout is fixed; any other width pairing is a build error.
  if (CODE_WIDTH != DATA_WIDTH + $bits(ENC_TAG)) begin : g_width_err
    $error("test_encoder: CODE_WIDTH must equal DATA_WIDTH + 4");
  end

  assign codeword = {data_in, ENC_TAG};
endmodule

// File: rtl/ecc_enc_arbiter.sv
// Round-robin arbiter sharing one ECC encoder among NUM_REQ requesters,
// followed by a one-entry registered output stage with valid/ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_data  per-requester request (data slice i*DATA_WIDTH)
//   req_ready           one-hot accept strobe
//   out_valid/out_ready codeword handshake to the sink
//   out_codeword/out_id registered codeword and its requester index
//   busy                output stage stalled (valid && !ready)
//   encode_count        saturating count of accepted requests
module ecc_enc_arbiter
  import ecc_enc_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CODE_WIDTH = CODE_W_DEF,
  parameter int ID_WIDTH   = id_width(NUM_REQ),
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [CODE_WIDTH-1:0]         out_codeword,
  output logic [ID_WIDTH-1:0]           out_id,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          encode_count
);
  if ((1 << ID_WIDTH) < NUM_REQ) begin : g_id_err
    $error("ecc_enc_arbiter: ID_WIDTH too small for NUM_REQ");
  end

  logic [0:0]                           state;
  logic [ID_WIDTH-1:0]                  ptr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_arr;
  logic [NUM_REQ-1:0]                   win;
  logic [ID_WIDTH-1:0]                  win_id;
  logic                                 found;
  logic                                 can_accept;
  logic                                 accept;
  logic [CODE_WIDTH-1:0]                enc_cw;
  int                                   idx;

  assign data_arr   = req_data;
  assign out_valid  = (state == ST_FULL);
  assign busy       = out_valid && !out_ready;
  // The stage can take a new codeword if empty or draining this cycle.
  assign can_accept = !out_valid || out_ready;

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    win    = '0;
    idx    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = ID_WIDTH'(idx);
      end
    end
    if (found) win[win_id] = 1'b1;
  end

  assign req_ready = (!rst && can_accept) ? win : '0;
  assign accept    = |(req_valid & req_ready);

  test_encoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .CODE_WIDTH (CODE_WIDTH)
  ) u_enc (
    .data_in  (data_arr[win_id]),
    .codeword (enc_cw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      out_codeword <= '0;
      out_id       <= '0;
      encode_count <= '0;
    end else begin
      if (accept) begin
        // Load (or replace a draining entry) in one edge for full throughput.
        state        <= ST_FULL;
        out_codeword <= enc_cw;
        out_id       <= win_id;
        ptr          <= (win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        if (encode_count != '1) encode_count <= encode_count + 1'b1;
      end else if (out_ready) begin
        state <= ST_IDLE;
      end
    end
  end
endmodule
